// File: rtl/kmeans_pkg.sv
// Shared constants, payload types and arithmetic helpers for the k-means
// centroid accumulation stage.
package kmeans_pkg;

  localparam int unsigned NUM_CENTROIDS = 16;
  localparam int unsigned PTR_W         = $clog2(NUM_CENTROIDS);
  localparam int unsigned IDX_W         = 16;
  localparam int unsigned COORD_W       = 64;
  localparam int unsigned SUM_W         = 80;
  localparam int unsigned CNT_W         = 16;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } point_t;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [SUM_W-1:0] sum_x;
    logic [SUM_W-1:0] sum_y;
    logic [SUM_W-1:0] sum_z;
    logic [CNT_W-1:0] count;
    logic             last;
  } centroid_result_t;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  function automatic logic [SUM_W-1:0] sext_coord(input logic [COORD_W-1:0] c);
    return {{(SUM_W-COORD_W){c[COORD_W-1]}}, c};
  endfunction

  // Two's-complement overflow: equal operand signs, result sign differs.
  function automatic logic add_ovf(input logic [SUM_W-1:0] a,
                                   input logic [SUM_W-1:0] b,
                                   input logic [SUM_W-1:0] s);
    return (a[SUM_W-1] == b[SUM_W-1]) && (s[SUM_W-1] != a[SUM_W-1]);
  endfunction

endpackage

// File: rtl/kmeans_accum_entry.sv
// One centroid accumulator: three wrapping coordinate sums plus a saturating
// member count, with clear and overflow reporting.
module kmeans_accum_entry
  import kmeans_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             add_en,
  input  logic             clr_en,
  input  point_t           pt,
  output logic [SUM_W-1:0] sum_x,
  output logic [SUM_W-1:0] sum_y,
  output logic [SUM_W-1:0] sum_z,
  output logic [CNT_W-1:0] count,
  output logic             ovf_c
);

  logic [SUM_W-1:0] ext_x, ext_y, ext_z;
  logic [SUM_W-1:0] nxt_x, nxt_y, nxt_z;
  logic             cnt_sat;

  always_comb begin
    ext_x   = sext_coord(pt.x);
    ext_y   = sext_coord(pt.y);
    ext_z   = sext_coord(pt.z);
    nxt_x   = sum_x + ext_x;
    nxt_y   = sum_y + ext_y;
    nxt_z   = sum_z + ext_z;
    cnt_sat = (count == {CNT_W{1'b1}});
    ovf_c   = add_en && (add_ovf(sum_x, ext_x, nxt_x) ||
                         add_ovf(sum_y, ext_y, nxt_y) ||
                         add_ovf(sum_z, ext_z, nxt_z) ||
                         cnt_sat);
  end

  // Clear wins over add; the two are never requested together by the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_x <= '0;
      sum_y <= '0;
      sum_z <= '0;
      count <= '0;
    end else if (clr_en) begin
      sum_x <= '0;
      sum_y <= '0;
      sum_z <= '0;
      count <= '0;
    end else if (add_en) begin
      sum_x <= nxt_x;
      sum_y <= nxt_y;
      sum_z <= nxt_z;
      if (!cnt_sat) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/kmeans_centroid_accumulator.sv
// Accumulates per-centroid coordinate sums and counts over one pass of tagged
// points, then drains one result beat per centroid and re-arms.
module kmeans_centroid_accumulator
  import kmeans_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bits_centeroidsFinished,
  input  logic               in_bits_pointsFinished,
  input  logic [IDX_W-1:0]   in_bits_centeroidIndex,
  input  logic [COORD_W-1:0] in_bits_point_x,
  input  logic [COORD_W-1:0] in_bits_point_y,
  input  logic [COORD_W-1:0] in_bits_point_z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_bits_centeroidIndex,
  output logic [SUM_W-1:0]   out_bits_sum_x,
  output logic [SUM_W-1:0]   out_bits_sum_y,
  output logic [SUM_W-1:0]   out_bits_sum_z,
  output logic [CNT_W-1:0]   out_bits_count,
  output logic               out_bits_last,
  output logic               err_badIndex,
  output logic               err_overflow,
  output logic               busy
);

  state_t                 state, state_next;
  logic [PTR_W-1:0]       ptr, ptr_next;
  centroid_result_t       out_q, out_next;
  logic                   err_bad_next, err_ovf_next;
  logic                   load_out;

  point_t                 pt;
  logic                   in_fire, out_fire, last_fire;
  logic                   idx_ok, mark, add_any, bad;
  logic [NUM_CENTROIDS-1:0] add_en, clr_en, ovf_vec;

  logic [SUM_W-1:0]       ent_sum_x [NUM_CENTROIDS];
  logic [SUM_W-1:0]       ent_sum_y [NUM_CENTROIDS];
  logic [SUM_W-1:0]       ent_sum_z [NUM_CENTROIDS];
  logic [CNT_W-1:0]       ent_count [NUM_CENTROIDS];

  // Input classification: marker beats beat centroid-load beats beat points.
  always_comb begin
    pt.x      = in_bits_point_x;
    pt.y      = in_bits_point_y;
    pt.z      = in_bits_point_z;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    idx_ok    = (in_bits_centeroidIndex < IDX_W'(NUM_CENTROIDS));
    mark      = in_fire && in_bits_pointsFinished;
    add_any   = in_fire && !in_bits_pointsFinished && !in_bits_centeroidsFinished && idx_ok;
    bad       = in_fire && !in_bits_pointsFinished && !in_bits_centeroidsFinished && !idx_ok;
    last_fire = out_fire && (ptr == PTR_W'(NUM_CENTROIDS - 1));
    for (int i = 0; i < int'(NUM_CENTROIDS); i++) begin
      add_en[i] = add_any && (in_bits_centeroidIndex[PTR_W-1:0] == PTR_W'(i));
      clr_en[i] = out_fire && (ptr == PTR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CENTROIDS; g++) begin : g_entry
    kmeans_accum_entry u_entry (
      .clk    (clk),
      .reset  (reset),
      .add_en (add_en[g]),
      .clr_en (clr_en[g]),
      .pt     (pt),
      .sum_x  (ent_sum_x[g]),
      .sum_y  (ent_sum_y[g]),
      .sum_z  (ent_sum_z[g]),
      .count  (ent_count[g]),
      .ovf_c  (ovf_vec[g])
    );
  end

  // Next-state, drain pointer, sticky errors and the next output beat.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    out_next     = out_q;
    err_bad_next = err_badIndex;
    err_ovf_next = err_overflow;
    load_out     = 1'b0;

    case (state)
      ST_ACCUM: begin
        if (bad) begin
          err_bad_next = 1'b1;
        end
        if (|ovf_vec) begin
          err_ovf_next = 1'b1;
        end
        if (mark) begin
          state_next = ST_DRAIN;
          ptr_next   = '0;
          load_out   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          ptr_next = ptr + PTR_W'(1);
          if (last_fire) begin
            state_next   = ST_ACCUM;
            err_bad_next = 1'b0;
            err_ovf_next = 1'b0;
            out_next     = '0;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_ACCUM;
      end
    endcase

    // Entries are static while draining, so the next beat is pre-registered.
    if (load_out) begin
      out_next.index = IDX_W'(ptr_next);
      out_next.sum_x = ent_sum_x[ptr_next];
      out_next.sum_y = ent_sum_y[ptr_next];
      out_next.sum_z = ent_sum_z[ptr_next];
      out_next.count = ent_count[ptr_next];
      out_next.last  = (ptr_next == PTR_W'(NUM_CENTROIDS - 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_ACCUM;
      ptr          <= '0;
      out_q        <= '0;
      err_badIndex <= 1'b0;
      err_overflow <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      ptr          <= ptr_next;
      out_q        <= out_next;
      err_badIndex <= err_bad_next;
      err_overflow <= err_ovf_next;
      in_ready     <= (state_next == ST_ACCUM);
      out_valid    <= (state_next == ST_DRAIN);
      busy         <= (state_next == ST_DRAIN);
    end
  end

  assign out_bits_centeroidIndex = out_q.index;
  assign out_bits_sum_x          = out_q.sum_x;
  assign out_bits_sum_y          = out_q.sum_y;
  assign out_bits_sum_z          = out_q.sum_z;
  assign out_bits_count          = out_q.count;
  assign out_bits_last           = out_q.last;

endmodule
